// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_unit
//  Description : Single-outstanding data memory with byte/half/word access,
//                sign/zero-extending loads, fault detection and a
//                configurable fixed response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit #(
    parameter int RAM_WORDS  = 72000,
    parameter int LATENCY    = 1,
    parameter int REGION_BIT = 24,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic [1:0]       resp_fault
);

    localparam int         c_IDX_W    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [29:0] c_WORD_LIM = 30'(RAM_WORDS);
    localparam logic [1:0] c_CNT_INIT = 2'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         fault_q;

    // Storage is deliberately outside the reset domain.
    logic [31:0]        mem_q [RAM_WORDS];

    logic               w_accept;
    logic [1:0]         w_fault;
    logic [c_IDX_W-1:0] w_idx;
    logic [4:0]         w_shamt;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_sh;
    logic [31:0]        w_word;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load;

    assign req_ready  = (state_q == c_IDLE) || ((state_q == c_RESP) && resp_ready);
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (state_q == c_RESP);
    assign resp_rdata = rdata_q;
    assign resp_tag   = tag_q;
    assign resp_fault = fault_q;

    assign w_idx      = req_addr[c_IDX_W+1:2];
    assign w_shamt    = {req_addr[1:0], 3'b000};
    assign w_wdata_sh = req_wdata << w_shamt;
    assign w_word     = mem_q[w_idx];
    assign w_shifted  = w_word >> w_shamt;

    // Fault classification: bad size beats range, range beats alignment.
    always_comb begin
        w_fault = 2'd0;
        if (req_size == 2'd3) begin
            w_fault = 2'd3;
        end else if (req_addr[REGION_BIT] || (req_addr[31:2] >= c_WORD_LIM)) begin
            w_fault = 2'd2;
        end else if (((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'd0))) begin
            w_fault = 2'd1;
        end
    end

    // Byte-lane enables for stores and lane extraction for loads.
    always_comb begin
        w_be   = 4'b1111;
        w_load = w_word;
        case (req_size)
            2'd0: begin
                w_be   = 4'b0001 << req_addr[1:0];
                w_load = {{24{~req_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            end
            2'd1: begin
                w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                w_load = {{16{~req_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                w_be   = 4'b1111;
                w_load = w_word;
            end
        endcase
        rdata_d = ((w_fault != 2'd0) || req_we) ? 32'd0 : w_load;
    end

    // Store write on the accept edge; faulting requests never touch memory.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && (w_fault == 2'd0)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Control FSM: an accept always (re)starts the latency sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: ;
            c_WAIT: begin
                if (cnt_q <= 2'd1) begin
                    state_d = c_RESP;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            c_RESP: begin
                if (resp_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
        if (w_accept) begin
            if (LATENCY == 1) begin
                state_d = c_RESP;
                cnt_d   = 2'd0;
            end else begin
                state_d = c_WAIT;
                cnt_d   = c_CNT_INIT;
            end
        end
    end

    // State, counter and response registers; in-flight work is dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= 32'd0;
            tag_q   <= '0;
            fault_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                rdata_q <= rdata_d;
                tag_q   <= req_tag;
                fault_q <= w_fault;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_unit
//  Description : Self-checking bench for data_mem_unit, one instance with
//                LATENCY=1 and one with LATENCY=3, against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  tag;
        logic [1:0]  fault;
    } exp_t;

    localparam int RW  [2] = '{72000, 1024};
    localparam int LAT [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst [2];
    logic        rv  [2];
    logic        rdy [2];
    logic [31:0] ra  [2];
    logic        rw  [2];
    logic [1:0]  rs  [2];
    logic        ru  [2];
    logic [31:0] rwd [2];
    logic [7:0]  rt  [2];
    logic        vv  [2];
    logic        rr  [2];
    logic [31:0] rd  [2];
    logic [7:0]  tg  [2];
    logic [1:0]  ft  [2];

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mm [int];
    int          outst [2];
    int          since [2];
    int          n_acc [2];
    int          n_resp [2];
    exp_t        pend [2];
    logic [31:0] last_rd [2];
    logic [1:0]  last_ft [2];
    logic [7:0]  last_tg [2];

    always #5 clk = ~clk;

    data_mem_unit #(.RAM_WORDS(72000), .LATENCY(1), .REGION_BIT(24), .TAG_W(8)) u_dut_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_addr(ra[0]),
        .req_we(rw[0]), .req_size(rs[0]), .req_unsigned(ru[0]), .req_wdata(rwd[0]),
        .req_tag(rt[0]), .resp_valid(vv[0]), .resp_ready(rr[0]), .resp_rdata(rd[0]),
        .resp_tag(tg[0]), .resp_fault(ft[0])
    );

    data_mem_unit #(.RAM_WORDS(1024), .LATENCY(3), .REGION_BIT(24), .TAG_W(8)) u_dut_l3 (
        .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_addr(ra[1]),
        .req_we(rw[1]), .req_size(rs[1]), .req_unsigned(ru[1]), .req_wdata(rwd[1]),
        .req_tag(rt[1]), .resp_valid(vv[1]), .resp_ready(rr[1]), .resp_rdata(rd[1]),
        .resp_tag(tg[1]), .resp_fault(ft[1])
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Reference behaviour: memory as bytes, faults decided from the address rules.
    function automatic exp_t model(input int d, input logic [31:0] a, input logic [1:0] sz,
                                   input logic we, input logic uns, input logic [31:0] wd,
                                   input logic [7:0] tag);
        exp_t        e;
        int          key;
        int          lane;
        int          nb;
        logic [7:0]  b [4];
        logic [31:0] word;
        logic [31:0] v;
        e.tag   = tag;
        e.rdata = 32'd0;
        if (sz == 2'd3)                                     e.fault = 2'd3;
        else if (a[24] || ((a >> 2) >= RW[d]))              e.fault = 2'd2;
        else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) e.fault = 2'd1;
        else                                                e.fault = 2'd0;
        if (e.fault == 2'd0) begin
            key  = d * (1 << 24) + int'(a >> 2);
            word = mm.exists(key) ? mm[key] : 32'hxxxx_xxxx;
            lane = int'(a[1:0]);
            nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
            if (we) begin
                for (int k = 0; k < nb; k++) b[lane + k] = wd[8*k +: 8];
                mm[key] = {b[3], b[2], b[1], b[0]};
            end else begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = b[lane + k];
                if (!uns && nb < 4 && v[8*nb-1])
                    for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // One clock of traffic on instance d with resp_ready high; entered and left at posedge+1.
    task automatic step(input int d);
        logic ev;
        logic acc;
        rr[d] = 1'b1;
        @(negedge clk);
        ev = (outst[d] != 0) && (since[d] >= LAT[d] - 1);
        chk($sformatf("valid%0d", d), {31'd0, vv[d]}, {31'd0, ev});
        if (ev) begin
            chk($sformatf("rdata%0d", d), rd[d], pend[d].rdata);
            chk($sformatf("tag%0d", d), {24'd0, tg[d]}, {24'd0, pend[d].tag});
            chk($sformatf("fault%0d", d), {30'd0, ft[d]}, {30'd0, pend[d].fault});
            last_rd[d] = rd[d];
            last_ft[d] = ft[d];
            last_tg[d] = tg[d];
            n_resp[d]++;
            outst[d] = 0;
        end
        chk($sformatf("ready%0d", d), {31'd0, rdy[d]}, {31'd0, (outst[d] == 0)});
        acc = rv[d] && rdy[d];
        if (acc) begin
            pend[d] = model(d, ra[d], rs[d], rw[d], ru[d], rwd[d], rt[d]);
            n_acc[d]++;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            outst[d] = 1;
            since[d] = 0;
        end else if (outst[d] != 0) begin
            since[d]++;
        end
    endtask

    task automatic send(input int d, input logic [31:0] a, input logic [1:0] sz, input logic we,
                        input logic uns, input logic [31:0] wd, input logic [7:0] tag);
        int a0;
        a0     = n_acc[d];
        rv[d]  = 1'b1;
        ra[d]  = a;
        rs[d]  = sz;
        rw[d]  = we;
        ru[d]  = uns;
        rwd[d] = wd;
        rt[d]  = tag;
        for (int i = 0; i < 8 && n_acc[d] == a0; i++) step(d);
        rv[d] = 1'b0;
        if (n_acc[d] == a0) chk("acc_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 8 && outst[d] != 0; i++) step(d);
        if (outst[d] != 0) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_fields(input int d);
        int r;
        int lane;
        r    = int'($urandom % 16);
        lane = int'($urandom % 4);
        case (r)
            0:       ra[d] = 32'(RW[d] * 4 + lane);
            1:       ra[d] = 32'h0100_0100 + 32'(lane);
            2:       ra[d] = 32'((RW[d] - 1) * 4 + lane);
            default: ra[d] = 32'h100 + 32'(($urandom % 16) * 4 + lane);
        endcase
        rs[d]  = 2'($urandom % 4);
        rw[d]  = 1'($urandom % 2);
        ru[d]  = 1'($urandom % 2);
        rwd[d] = $urandom;
        rt[d]  = 8'($urandom);
    endtask

    task automatic rand_stream(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            rv[d] = (($urandom % 4) != 0);
            rand_fields(d);
            step(d);
        end
        rv[d] = 1'b0;
        for (int i = 0; i < 8 && outst[d] != 0; i++) step(d);
        if (outst[d] != 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse(input int d);
        rst[d] = 1'b0;
        #1;
        chk("rst_valid", {31'd0, vv[d]}, 32'd0);
        chk("rst_rdata", rd[d], 32'd0);
        chk("rst_tag", {24'd0, tg[d]}, 32'd0);
        chk("rst_fault", {30'd0, ft[d]}, 32'd0);
        @(posedge clk);
        #1;
        rst[d]   = 1'b1;
        outst[d] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   acc0;
        int   resp0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = 1'b0; ra[d] = '0; rw[d] = 1'b0; rs[d] = '0;
            ru[d] = 1'b0; rwd[d] = '0; rt[d] = '0; rr[d] = 1'b1;
            outst[d] = 0; since[d] = 0; n_acc[d] = 0; n_resp[d] = 0;
        end
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("init_valid", {31'd0, vv[d]}, 32'd0);
            chk("init_rdata", rd[d], 32'd0);
            chk("init_tag", {24'd0, tg[d]}, 32'd0);
            chk("init_fault", {30'd0, ft[d]}, 32'd0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        #1;
        chk("init_ready0", {31'd0, rdy[0]}, 32'd1);
        chk("init_ready1", {31'd0, rdy[1]}, 32'd1);
        @(posedge clk);
        #1;

        // Signed / unsigned byte extraction.
        send(0, 32'h100, 2'd2, 1'b1, 1'b0, 32'hDEADBEEF, 8'h01);
        chk("st_rdata", last_rd[0], 32'd0);
        send(0, 32'h101, 2'd0, 1'b0, 1'b0, 32'd0, 8'h02);
        chk("ldb_signed", last_rd[0], 32'hFFFFFFBE);
        chk("ldb_signed_ft", {30'd0, last_ft[0]}, 32'd0);
        send(0, 32'h101, 2'd0, 1'b0, 1'b1, 32'd0, 8'h03);
        chk("ldb_unsigned", last_rd[0], 32'h000000BE);

        // Half store merges into an existing word.
        send(0, 32'h200, 2'd2, 1'b1, 1'b0, 32'hAAAAAAAA, 8'h04);
        send(0, 32'h202, 2'd1, 1'b1, 1'b0, 32'h00001234, 8'h05);
        send(0, 32'h200, 2'd2, 1'b0, 1'b0, 32'd0, 8'h06);
        chk("half_merge", last_rd[0], 32'h1234AAAA);

        // Faults, including faulting stores that must not alter memory.
        send(0, 32'h103, 2'd2, 1'b0, 1'b0, 32'd0, 8'h07);
        chk("misalign_ft", {30'd0, last_ft[0]}, 32'd1);
        chk("misalign_rd", last_rd[0], 32'd0);
        send(0, 32'h0100_0000, 2'd2, 1'b0, 1'b0, 32'd0, 8'h08);
        chk("region_ft", {30'd0, last_ft[0]}, 32'd2);
        send(0, 32'h100, 2'd3, 1'b0, 1'b0, 32'd0, 8'h09);
        chk("badsize_ft", {30'd0, last_ft[0]}, 32'd3);
        send(0, 32'h0100_0100, 2'd2, 1'b1, 1'b0, 32'h55555555, 8'h0A);
        send(0, 32'h100, 2'd3, 1'b1, 1'b0, 32'h66666666, 8'h0B);
        send(0, 32'h102, 2'd2, 1'b1, 1'b0, 32'h77777777, 8'h0C);
        send(0, 32'(72000 * 4), 2'd2, 1'b1, 1'b0, 32'h88888888, 8'h0D);
        chk("range_ft", {30'd0, last_ft[0]}, 32'd2);
        send(0, 32'h100, 2'd2, 1'b0, 1'b0, 32'd0, 8'h0E);
        chk("mem_unchanged", last_rd[0], 32'hDEADBEEF);

        // Preload the random pool on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) send(d, 32'h100 + 32'(w * 4), 2'd2, 1'b1, 1'b0, $urandom, 8'(w));
            send(d, 32'((RW[d] - 1) * 4), 2'd2, 1'b1, 1'b0, $urandom, 8'hEE);
        end

        // Back-to-back: request held valid, one response per cycle, tags in order.
        acc0  = n_acc[0];
        resp0 = n_resp[0];
        for (int i = 0; i < 100; i++) begin
            rand_fields(0);
            rv[0] = 1'b1;
            rt[0] = 8'(i);
            step(0);
        end
        rv[0] = 1'b0;
        for (int i = 0; i < 4 && outst[0] != 0; i++) step(0);
        chk("b2b_acc", 32'(n_acc[0] - acc0), 32'd100);
        chk("b2b_resp", 32'(n_resp[0] - resp0), 32'd100);

        // LATENCY=3 with the response stalled for six cycles.
        rv[1] = 1'b1; ra[1] = 32'h104; rs[1] = 2'd2; rw[1] = 1'b0; ru[1] = 1'b0; rt[1] = 8'h5A;
        rr[1] = 1'b0;
        @(negedge clk);
        chk("hold_ready_idle", {31'd0, rdy[1]}, 32'd1);
        e = model(1, ra[1], rs[1], rw[1], ru[1], rwd[1], rt[1]);
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, vv[1]}, {31'd0, (c >= 2)});
            if (c >= 2) begin
                chk("hold_rdata", rd[1], e.rdata);
                chk("hold_tag", {24'd0, tg[1]}, {24'd0, e.tag});
                chk("hold_fault", {30'd0, ft[1]}, {30'd0, e.fault});
            end
            chk("hold_ready", {31'd0, rdy[1]}, 32'd0);
            @(posedge clk);
            #1;
        end
        rr[1] = 1'b1;
        #1;
        chk("hold_ready_rel", {31'd0, rdy[1]}, 32'd1);
        @(posedge clk);
        #1;
        chk("hold_done", {31'd0, vv[1]}, 32'd0);

        // Reset while waiting: request dropped, its store stays written.
        rv[1] = 1'b1; ra[1] = 32'h140; rs[1] = 2'd2; rw[1] = 1'b1; ru[1] = 1'b0;
        rwd[1] = 32'hCAFEF00D; rt[1] = 8'h21;
        step(1);
        rv[1] = 1'b0;
        step(1);
        reset_pulse(1);
        send(1, 32'h140, 2'd2, 1'b0, 1'b0, 32'd0, 8'h77);
        chk("post_rst_tag", {24'd0, last_tg[1]}, 32'h77);
        chk("post_rst_data", last_rd[1], 32'hCAFEF00D);

        // Randomized mixed traffic on both latencies.
        rand_stream(0, 300);
        rand_stream(1, 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
